// File: rtl/ap3_io_pkg.sv
// ---------------------------------------------------------------------------
// ap3_io_pkg
// Shared constants and helpers for the AP3 IO block register cells.
//   - Legal parameter ranges for the input-cell synchronizer and filter.
//   - clog2 helper for sizing counters at elaboration time.
// ---------------------------------------------------------------------------
package ap3_io_pkg;

   // Legal synchronizer depth for pad-input cells
   localparam int unsigned SYNC_STAGES_MIN = 2;
   localparam int unsigned SYNC_STAGES_MAX = 4;

   // Legal glitch-filter length (1 = filter bypassed)
   localparam int unsigned FILTER_LEN_MIN  = 1;
   localparam int unsigned FILTER_LEN_MAX  = 16;

   // Ceiling log2; clog2(0) = clog2(1) = 0
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned pow;
      res = 0;
      pow = 1;
      while (pow < value) begin
         pow = pow << 1;
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/in_sync_chain.sv
// ---------------------------------------------------------------------------
// in_sync_chain
// Metastability synchronizer: SYNC_STAGES flops in series, synchronous
// active-high reset loads INIT into every stage.
// Ports:
//   clk  in  1  sampling clock
//   rst  in  1  synchronous active-high reset
//   d    in  1  asynchronous input
//   q    out 1  synchronized output (last stage)
// ---------------------------------------------------------------------------
module in_sync_chain
   import ap3_io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        INIT        = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("in_sync_chain: SYNC_STAGES=%0d out of range", SYNC_STAGES);
   end

   logic [SYNC_STAGES-1:0] sync;

   // Shift register; stage 0 samples the pad, the last stage feeds the filter
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= {SYNC_STAGES{INIT}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync[SYNC_STAGES-1];

endmodule

// File: rtl/in_filter_cell.sv
// ---------------------------------------------------------------------------
// in_filter_cell
// Input-direction IO register cell: pad level -> synchronizer -> consecutive
// sample glitch filter -> registered level plus one-cycle edge strobes.
// Ports:
//   IQC  in  1  IO register clock
//   QRT  in  1  synchronous active-high reset
//   IQE  in  1  clock enable for the filter stage (synchronizer always runs)
//   A2F  in  1  asynchronous pad input
//   IQZ  out 1  filtered registered level
//   IQR  out 1  one-cycle strobe, IQZ rose
//   IQF  out 1  one-cycle strobe, IQZ fell
// ---------------------------------------------------------------------------
module in_filter_cell
   import ap3_io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4,
   parameter logic        INIT        = 1'b0
) (
   input  logic IQC,
   input  logic QRT,
   input  logic IQE,
   input  logic A2F,
   output logic IQZ,
   output logic IQR,
   output logic IQF
);

   localparam int unsigned CNT_W = (clog2(FILTER_LEN) > 1) ? clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
      $error("in_filter_cell: FILTER_LEN=%0d out of range", FILTER_LEN);
   end

   logic             s;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             iqz_nxt;
   logic             iqr_nxt;
   logic             iqf_nxt;

   in_sync_chain #(
      .SYNC_STAGES (SYNC_STAGES),
      .INIT        (INIT)
   ) u_sync (
      .clk (IQC),
      .rst (QRT),
      .d   (A2F),
      .q   (s)
   );

   // Filter next state: a differing sample must persist FILTER_LEN enabled
   // cycles; any agreeing sample restarts the count from zero.
   always_comb begin
      cnt_nxt = cnt;
      iqz_nxt = IQZ;
      iqr_nxt = 1'b0;
      iqf_nxt = 1'b0;
      if (IQE) begin
         if (s == IQZ) begin
            cnt_nxt = '0;
         end else if (cnt == CNT_LAST) begin
            iqz_nxt = s;
            cnt_nxt = '0;
            iqr_nxt = s;
            iqf_nxt = ~s;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   // Reset wins over enable and over an update due on the same edge
   always_ff @(posedge IQC) begin
      if (QRT) begin
         cnt <= '0;
         IQZ <= INIT;
         IQR <= 1'b0;
         IQF <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         IQZ <= iqz_nxt;
         IQR <= iqr_nxt;
         IQF <= iqf_nxt;
      end
   end

endmodule

// File: tb/tb_in_filter_cell.sv
// ---------------------------------------------------------------------------
// tb_in_filter_cell
// Directed bench: each driven edge pushes its hand-derived expected
// {IQZ,IQR,IQF}; a per-DUT monitor pops and compares after every edge.
// dut_a uses defaults; dut_b uses INIT=1, FILTER_LEN=1.
// ---------------------------------------------------------------------------
module tb_in_filter_cell;

   typedef struct {
      string      name;
      int         ed;
      logic [2:0] v;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic qrt_a, iqe_a, a2f_a, iqz_a, iqr_a, iqf_a;
   logic qrt_b, iqe_b, a2f_b, iqz_b, iqr_b, iqf_b;

   int total = 0;
   int bad   = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   in_filter_cell dut_a (
      .IQC (clk),
      .QRT (qrt_a),
      .IQE (iqe_a),
      .A2F (a2f_a),
      .IQZ (iqz_a),
      .IQR (iqr_a),
      .IQF (iqf_a)
   );

   in_filter_cell #(
      .SYNC_STAGES (2),
      .FILTER_LEN  (1),
      .INIT        (1'b1)
   ) dut_b (
      .IQC (clk),
      .QRT (qrt_b),
      .IQE (iqe_b),
      .A2F (a2f_b),
      .IQZ (iqz_b),
      .IQR (iqr_b),
      .IQF (iqf_b)
   );

   // Monitors: outputs sampled 1 time unit after each rising edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         total++;
         if ({iqz_a, iqr_a, iqf_a} !== e.v) begin
            bad++;
            $display("FAIL dut_a %s edge %0d: got z/r/f=%b required %b", e.name, e.ed,
                     {iqz_a, iqr_a, iqf_a}, e.v);
         end
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         total++;
         if ({iqz_b, iqr_b, iqf_b} !== e.v) begin
            bad++;
            $display("FAIL dut_b %s edge %0d: got z/r/f=%b required %b", e.name, e.ed,
                     {iqz_b, iqr_b, iqf_b}, e.v);
         end
      end
   end

   task automatic step_a(input logic a, input logic e, input logic r,
                         input logic z, input logic rr, input logic ff,
                         input string name, input int n);
      exp_t x;
      @(negedge clk);
      a2f_a = a;
      iqe_a = e;
      qrt_a = r;
      x.name = name;
      x.ed   = n;
      x.v    = {z, rr, ff};
      q_a.push_back(x);
      @(posedge clk);
   endtask

   task automatic step_b(input logic a, input logic z, input logic rr, input logic ff,
                         input logic r, input string name, input int n);
      exp_t x;
      @(negedge clk);
      a2f_b = a;
      iqe_b = 1'b1;
      qrt_b = r;
      x.name = name;
      x.ed   = n;
      x.v    = {z, rr, ff};
      q_b.push_back(x);
      @(posedge clk);
   endtask

   // Toggle pattern for dut_b: A2F=0 at edges 1,2; 1 at 3,4; 0 at 5,6 ...
   function automatic logic pat_b(input int n);
      return ((n - 1) / 2) % 2 == 1;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic zb, zb_prev;
      qrt_a = 1'b1; iqe_a = 1'b1; a2f_a = 1'b0;
      qrt_b = 1'b1; iqe_b = 1'b1; a2f_b = 1'b0;
      repeat (2) @(posedge clk);

      // Steady 1 from edge 1: update and IQR at edge SYNC_STAGES+FILTER_LEN = 6
      for (int n = 0; n <= 8; n++)
         step_a(n != 0, 1'b1, n == 0, n >= 6, n == 6, 1'b0, "steady_rise", n);

      // 3-cycle pulse is rejected
      for (int n = 0; n <= 10; n++)
         step_a(n >= 1 && n <= 3, 1'b1, n == 0, 1'b0, 1'b0, 1'b0, "pulse3", n);

      // 4-cycle pulse passes: IQZ high edges 6..9, IQR at 6, IQF at 10
      for (int n = 0; n <= 12; n++)
         step_a(n >= 1 && n <= 4, 1'b1, n == 0, n >= 6 && n <= 9, n == 6, n == 10,
                "pulse4", n);

      // Count restart: 1,1,1,0,1,1,1,1 -> rise at 10, fall at 14
      for (int n = 0; n <= 15; n++)
         step_a((n >= 1 && n <= 3) || (n >= 5 && n <= 8), 1'b1, n == 0,
                n >= 10 && n <= 13, n == 10, n == 14, "restart", n);

      // IQE low at edges 4,5 delays the update to edge 8
      for (int n = 0; n <= 10; n++)
         step_a(n != 0, !(n == 4 || n == 5), n == 0, n >= 8, n == 8, 1'b0,
                "enable_gap", n);

      // Reset at edge 5 discards a pending rise; requalified at edge 11
      for (int n = 0; n <= 12; n++)
         step_a(n != 0, 1'b1, n == 0 || n == 5, n >= 11, n == 11, 1'b0,
                "mid_reset", n);

      // INIT=1, FILTER_LEN=1: IQZ follows A2F two edges later
      step_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "init1_reset", 0);
      zb_prev = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         zb = (n < 3) ? 1'b1 : pat_b(n - 2);
         step_b(pat_b(n), zb, zb & ~zb_prev, ~zb & zb_prev, 1'b0, "follow", n);
         zb_prev = zb;
      end

      repeat (3) @(posedge clk);
      #2;
      total++;
      if (q_a.size() + q_b.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d unchecked entries, required 0",
                  q_a.size() + q_b.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
